dm_arbiter: RTL and testbench

Two-port access controller for the single-port data memory. It arbitrates round-robin between the CPU memory-stage port (port 0) and a DMA/debug port (port 1). For the winning request it generates byte enables and lane-replicated write data, checks alignment and range, and returns lane-extracted, sign- or zero-extended read data. It sits between the pipeline/DMA and the data memory array and is the only block driving the memory's write strobe.

---
 rtl/dm_arb_pkg.sv | 18 +
 rtl/dm_lane_ctl.sv | 50 +++++
 rtl/dm_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states, port ids.
package dm_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dm_lane_ctl.sv
// Combinational lane steering: byte enables, replicated write data,
// extracted/extended read data and alignment/size error for one access.
module dm_lane_ctl
    import dm_arb_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rd,
    input  logic        sext,
    output logic [3:0]  be,
    output logic [31:0] wd,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [15:0] lane;

    // Decode size/offset into lane controls and extend the selected read lane.
    always_comb begin
        be       = '0;
        wd       = '0;
        rdata    = '0;
        misalign = 1'b0;
        lane     = 16'(mem_rd >> {addr_lo, 3'b000});
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wd    = {4{wdata[7:0]}};
                rdata = {{24{sext & lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wd       = {2{wdata[15:0]}};
                rdata    = {{16{sext & lane[15]}}, lane[15:0]};
            end
            SZ_WORD: begin
                misalign = |addr_lo;
                be       = 4'b1111;
                wd       = wdata;
                rdata    = mem_rd;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin two-port access controller for the single-port data memory.
// One access per three cycles: accept (IDLE) -> memory access -> response.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DEPTH_W = 12
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               p0_valid,
    input  logic               p0_we,
    input  logic [31:0]        p0_addr,
    input  logic [1:0]         p0_size,
    input  logic               p0_sext,
    input  logic [31:0]        p0_wdata,
    output logic               p0_ready,
    output logic               p0_rvalid,
    output logic [31:0]        p0_rdata,
    output logic               p0_err,
    input  logic               p1_valid,
    input  logic               p1_we,
    input  logic [31:0]        p1_addr,
    input  logic [1:0]         p1_size,
    input  logic               p1_sext,
    input  logic [31:0]        p1_wdata,
    output logic               p1_ready,
    output logic               p1_rvalid,
    output logic [31:0]        p1_rdata,
    output logic               p1_err,
    output logic               mem_wr,
    output logic [DEPTH_W-1:0] mem_addr,
    output logic [3:0]         mem_be,
    output logic [31:0]        mem_wd,
    input  logic [31:0]        mem_rd
);

    state_t      state, state_nx;
    logic        ptr;
    logic        any_valid;
    logic        win;

    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [31:0] r_wdata;
    logic        r_id;
    logic [31:0] resp_data;
    logic        resp_err;

    logic [3:0]  l_be;
    logic [31:0] l_wd;
    logic [31:0] l_rdata;
    logic        l_misalign;
    logic        range_err;
    logic        err;

    dm_lane_ctl u_lane (
        .addr_lo  (r_addr[1:0]),
        .size     (r_size),
        .wdata    (r_wdata),
        .mem_rd   (mem_rd),
        .sext     (r_sext),
        .be       (l_be),
        .wd       (l_wd),
        .rdata    (l_rdata),
        .misalign (l_misalign)
    );

    assign range_err = |r_addr[31:DEPTH_W+2];
    assign err       = l_misalign | range_err;

    // Arbitration: a lone requester wins; on contention the pointer decides.
    always_comb begin
        any_valid = p0_valid | p1_valid;
        win       = (p0_valid & p1_valid) ? ptr : p1_valid;
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state and all outputs, decoded from the current state.
    always_comb begin
        state_nx  = state;
        p0_ready  = 1'b0;
        p1_ready  = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        p0_rdata  = '0;
        p1_rdata  = '0;
        p0_err    = 1'b0;
        p1_err    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wd    = '0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    p0_ready = (win == PORT_CPU);
                    p1_ready = (win == PORT_DMA);
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = r_addr[DEPTH_W+1:2];
                mem_wd   = l_wd;
                mem_be   = err ? 4'b0000 : l_be;
                mem_wr   = r_we & ~err;
                state_nx = RESP;
            end
            RESP: begin
                if (r_id == PORT_CPU) begin
                    p0_rvalid = 1'b1;
                    p0_rdata  = resp_data;
                    p0_err    = resp_err;
                end else begin
                    p1_rvalid = 1'b1;
                    p1_rdata  = resp_data;
                    p1_err    = resp_err;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latch on grant, round-robin pointer, and response capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= PORT_CPU;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_size    <= '0;
            r_sext    <= 1'b0;
            r_wdata   <= '0;
            r_id      <= PORT_CPU;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            if (state == IDLE && any_valid) begin
                r_id    <= win;
                ptr     <= ~win;
                r_we    <= win ? p1_we    : p0_we;
                r_addr  <= win ? p1_addr  : p0_addr;
                r_size  <= win ? p1_size  : p0_size;
                r_sext  <= win ? p1_sext  : p0_sext;
                r_wdata <= win ? p1_wdata : p0_wdata;
            end
            if (state == ACCESS) begin
                resp_data <= (r_we | err) ? 32'h0 : l_rdata;
                resp_err  <= err;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a byte-addressed reference memory predicts
// every response and memory access; a separate monitor compares them.
module tb_dm_arbiter;

    localparam int DW = 12;

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [1:0]  size;
        bit        sext;
        bit [31:0] wdata;
    } req_t;

    typedef struct {
        int unsigned cyc;
        bit [31:0]   rdata;
        bit          err;
    } resp_t;

    typedef struct {
        int unsigned cyc;
        bit          wr;
        bit [DW-1:0] waddr;
        bit [3:0]    be;
        bit [31:0]   wd;
        bit          chk_wd;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic p0_valid, p0_we, p0_sext, p0_ready, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [1:0] p0_size;
    logic p1_valid, p1_we, p1_sext, p1_ready, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [1:0] p1_size;
    logic mem_wr;
    logic [DW-1:0] mem_addr;
    logic [3:0] mem_be;
    logic [31:0] mem_wd, mem_rd;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    bit mon_en = 1'b0;
    bit gap_en = 1'b0;

    req_t  cur [2];
    bit    act [2];
    req_t  stim0 [$];
    req_t  stim1 [$];
    resp_t resp_q0 [$];
    resp_t resp_q1 [$];
    acc_t  acc_q [$];
    int    grant_log [$];
    bit    mptr = 1'b0;
    int    busy = 0;

    logic [31:0] mem_arr [0:(1<<DW)-1];
    bit   [7:0]  ref_mem [0:(4<<DW)-1];

    dm_arbiter #(.DEPTH_W(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_size(p0_size),
        .p0_sext(p0_sext), .p0_wdata(p0_wdata), .p0_ready(p0_ready),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_size(p1_size),
        .p1_sext(p1_sext), .p1_wdata(p1_wdata), .p1_ready(p1_ready),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory array behind the arbiter: combinational read, byte-enabled write.
    assign mem_rd = mem_arr[mem_addr];
    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_wr) begin
            w = mem_arr[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) w[8*b +: 8] = mem_wd[8*b +: 8];
            mem_arr[mem_addr] <= w;
        end
    end

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act_v, exp_v, $time);
        end
    endtask

    // Reference model: predicts the memory cycle and the response of a granted request.
    task automatic model_accept(input int p, input req_t r);
        int nb;
        bit err;
        acc_t a;
        resp_t e;
        bit [63:0] val;
        nb  = (r.size == 2'b11) ? 0 : (1 << r.size);
        err = (nb == 0) || ((r.addr % 32'(nb)) != 0) || (r.addr >= 32'(4 << DW));
        a.cyc    = cyc + 1;
        a.wr     = r.we && !err;
        a.waddr  = DW'(r.addr / 4);
        a.be     = err ? 4'b0000 : 4'(((1 << nb) - 1) << (r.addr % 4));
        a.chk_wd = !err;
        a.wd     = '0;
        if (!err)
            for (int k = 0; k < 4; k++) a.wd[8*k +: 8] = r.wdata[8*(k % nb) +: 8];
        acc_q.push_back(a);
        e.cyc   = cyc + 2;
        e.err   = err;
        e.rdata = '0;
        if (!err) begin
            if (r.we) begin
                for (int i = 0; i < nb; i++) ref_mem[r.addr + 32'(i)] = r.wdata[8*i +: 8];
            end else begin
                val = '0;
                for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[r.addr + 32'(i)];
                if (r.sext && val[8*nb-1]) val = val | ~((64'd1 << (8*nb)) - 1);
                e.rdata = val[31:0];
            end
        end
        if (p == 0) resp_q0.push_back(e);
        else        resp_q1.push_back(e);
    endtask

    task automatic drive_ports();
        p0_valid = act[0]; p0_we = cur[0].we; p0_addr = cur[0].addr;
        p0_size  = cur[0].size; p0_sext = cur[0].sext; p0_wdata = cur[0].wdata;
        p1_valid = act[1]; p1_we = cur[1].we; p1_addr = cur[1].addr;
        p1_size  = cur[1].size; p1_sext = cur[1].sext; p1_wdata = cur[1].wdata;
    endtask

    // One cycle of stimulus: present pending requests, check the grant, feed the model.
    task automatic step();
        int w;
        @(negedge clk);
        if (!act[0] && stim0.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
            cur[0] = stim0.pop_front(); act[0] = 1'b1;
        end
        if (!act[1] && stim1.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
            cur[1] = stim1.pop_front(); act[1] = 1'b1;
        end
        drive_ports();
        #1;
        if (busy > 0) begin
            w = -1; busy--;
        end else if (act[0] && act[1]) w = mptr ? 1 : 0;
        else if (act[0]) w = 0;
        else if (act[1]) w = 1;
        else w = -1;
        chk("ready", {30'b0, p1_ready, p0_ready}, (w == 0) ? 32'd1 : (w == 1) ? 32'd2 : 32'd0);
        if (w >= 0) begin
            model_accept(w, cur[w]);
            mptr = (w == 0);
            act[w] = 1'b0;
            busy = 2;
            grant_log.push_back(w);
        end
    endtask

    task automatic run(input int max_steps);
        int n = 0;
        while ((stim0.size() > 0 || stim1.size() > 0 || act[0] || act[1] || busy > 0 ||
                resp_q0.size() > 0 || resp_q1.size() > 0 || acc_q.size() > 0) && n < max_steps) begin
            step();
            n++;
        end
        if (n >= max_steps)
            chk("drain_timeout", 32'(resp_q0.size() + resp_q1.size() + acc_q.size() + stim0.size() + stim1.size()), 32'd0);
    endtask

    function automatic req_t mk(input bit we, input bit [31:0] addr, input bit [1:0] size,
                                input bit sext, input bit [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.size = size; r.sext = sext; r.wdata = wdata;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int k;
        r.we    = 1'($urandom_range(0, 1));
        r.sext  = 1'($urandom_range(0, 1));
        r.wdata = $urandom;
        r.size  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r.addr  = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        if (r.size != 2'b11 && $urandom_range(0, 1) == 1)
            r.addr = r.addr & ~32'((1 << r.size) - 1);
        k = int'($urandom_range(0, 15));
        if (k == 0)      r.addr = r.addr | 32'h0001_0000;
        else if (k == 1) r.addr = r.addr + 32'h0000_3FC0;
        return r;
    endfunction

    task automatic check_resp(input int p, input logic rv, input logic [31:0] rd, input logic er);
        resp_t e;
        bit have;
        have = (p == 0) ? (resp_q0.size() > 0) : (resp_q1.size() > 0);
        if (have) e = (p == 0) ? resp_q0[0] : resp_q1[0];
        if (rv) begin
            if (!have) chk("rvalid_unexpected", {31'b0, rv}, 32'd0);
            else begin
                if (p == 0) void'(resp_q0.pop_front());
                else        void'(resp_q1.pop_front());
                chk("rvalid_cycle", cyc, e.cyc);
                chk("rdata", rd, e.rdata);
                chk("err", {31'b0, er}, {31'b0, e.err});
            end
        end else begin
            chk("rdata_idle", rd, 32'd0);
            chk("err_idle", {31'b0, er}, 32'd0);
            if (have && e.cyc <= cyc) begin
                if (p == 0) void'(resp_q0.pop_front());
                else        void'(resp_q1.pop_front());
                chk("rvalid_missing", {31'b0, rv}, 32'd1);
            end
        end
    endtask

    // Monitor: compares DUT outputs against the predicted queues each cycle.
    always @(negedge clk) begin
        acc_t a;
        if (mon_en) begin
            #2;
            check_resp(0, p0_rvalid, p0_rdata, p0_err);
            check_resp(1, p1_rvalid, p1_rdata, p1_err);
            if (acc_q.size() > 0 && acc_q[0].cyc <= cyc) begin
                a = acc_q.pop_front();
                chk("acc_cycle", cyc, a.cyc);
                chk("mem_wr", {31'b0, mem_wr}, {31'b0, a.wr});
                chk("mem_addr", 32'(mem_addr), 32'(a.waddr));
                chk("mem_be", {28'b0, mem_be}, {28'b0, a.be});
                if (a.chk_wd) chk("mem_wd", mem_wd, a.wd);
            end else begin
                chk("mem_wr_idle", {31'b0, mem_wr}, 32'd0);
                chk("mem_be_idle", {28'b0, mem_be}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [5:0] g;
        logic [31:0] saved;
        for (int i = 0; i < (1 << DW); i++) mem_arr[i] = '0;
        act[0] = 1'b0; act[1] = 1'b0;
        cur[0] = mk(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        cur[1] = cur[0];
        drive_ports();

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_resp", {28'b0, p0_rvalid, p0_err, p1_rvalid, p1_err}, 32'd0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;

        // Contention from reset: grants alternate starting with CPU
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            stim0.push_back(mk(1'b0, 32'(4 * i), 2'b10, 1'b0, 32'h0));
            stim1.push_back(mk(1'b0, 32'(32 + 4 * i), 2'b10, 1'b0, 32'h0));
        end
        run(100);
        g = '0;
        for (int i = 0; i < 6 && i < grant_log.size(); i++) g[i] = grant_log[i][0];
        chk("grant_count", 32'(grant_log.size()), 32'd6);
        chk("grant_order", {26'b0, g}, {26'b0, 6'b101010});

        // Word store, byte store into top lane, signed/unsigned byte loads
        stim0.push_back(mk(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF));
        stim1.push_back(mk(1'b1, 32'h13, 2'b00, 1'b0, 32'h0000_00A5));
        stim1.push_back(mk(1'b0, 32'h13, 2'b00, 1'b1, 32'h0));
        stim1.push_back(mk(1'b0, 32'h13, 2'b00, 1'b0, 32'h0));
        run(100);
        chk("mem_word4", mem_arr[4], 32'hA5AD_BEEF);

        // Error cases and the top of the address range
        stim0.push_back(mk(1'b0, 32'h3, 2'b01, 1'b1, 32'h0));
        stim0.push_back(mk(1'b1, 32'h2, 2'b10, 1'b0, 32'h1234_5678));
        stim0.push_back(mk(1'b0, 32'h0, 2'b11, 1'b0, 32'h0));
        stim0.push_back(mk(1'b1, 32'h3FFC, 2'b10, 1'b0, 32'hCAFE_F00D));
        stim0.push_back(mk(1'b0, 32'h3FFE, 2'b01, 1'b1, 32'h0));
        stim1.push_back(mk(1'b0, 32'h0001_0000, 2'b10, 1'b0, 32'h0));
        stim1.push_back(mk(1'b1, 32'h4000, 2'b00, 1'b0, 32'hFF));
        stim1.push_back(mk(1'b0, 32'h3FFD, 2'b00, 1'b0, 32'h0));
        run(200);

        // Randomized traffic on both ports with idle gaps
        gap_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            stim0.push_back(rand_req());
            stim1.push_back(rand_req());
        end
        run(3000);
        gap_en = 1'b0;

        // Reset during the access cycle of a store
        mon_en = 1'b0;
        saved = mem_arr[8];
        @(negedge clk);
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_size = 2'b10;
        p0_sext = 1'b0; p0_wdata = ~saved;
        p1_valid = 1'b0;
        #1;
        chk("abort_ready", {31'b0, p0_ready}, 32'd1);
        @(negedge clk);
        p0_valid = 1'b0;
        #1;
        chk("abort_access_wr", {31'b0, mem_wr}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_wr_drop", {31'b0, mem_wr}, 32'd0);
        chk("abort_be_drop", {28'b0, mem_be}, 32'd0);
        @(negedge clk); #1;
        chk("abort_no_commit", mem_arr[8], saved);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'd0);
            @(negedge clk); #1;
        end
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h0;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h4; p1_size = 2'b10;
        #1;
        chk("post_reset_grant", {30'b0, p1_ready, p0_ready}, 32'd1);
        @(negedge clk);
        p0_valid = 1'b0; p1_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
